mult_seq: RTL and testbench

- Iterative, parametrised signed/unsigned integer multiplier for the CPU datapath, serving MULT and MULTU.
- Retires RADIX_BITS multiplier bits per clock using a shift-add datapath, so it needs only one adder of WIDTH+RADIX_BITS bits.
- Uses a start/busy/done handshake. The result is held in a register so the HI/LO write-back logic can sample it at any time after done.

---
 rtl/mult_seq.sv | 140 ++++++++++++++
 tb/tb_mult_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - iterative shift-add signed/unsigned multiplier
//
// Purpose: multiplies two WIDTH-bit operands (MULT / MULTU) by retiring
// RADIX_BITS multiplier bits per clock through a single adder of
// WIDTH+RADIX_BITS bits. Signed products are formed on magnitudes and the
// sign is applied in a final fix-up cycle. Latency is WIDTH/RADIX_BITS+1
// edges from the accepted start to done, independent of operand values.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request a multiply; only sampled while idle
//   sign_mode  1 = signed, 0 = unsigned; sampled with start
//   a          multiplicand; sampled with start
//   b          multiplier; sampled with start
//   busy       high while an operation is in flight (RUN or FIX)
//   done       one-cycle pulse when z has just been updated
//   z          2*WIDTH-bit product register, held until the next completion

module mult_seq #(
   parameter int WIDTH      = 32,
   parameter int RADIX_BITS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 sign_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   z
);

   localparam int N  = WIDTH / RADIX_BITS;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t                    state;
   state_t                    state_next;

   logic [WIDTH-1:0]          mcand;
   logic [2*WIDTH-1:0]        p;
   logic [CW-1:0]             cnt;
   logic                      neg;

   logic [WIDTH-1:0]          mag_a;
   logic [WIDTH-1:0]          mag_b;
   logic [WIDTH+RADIX_BITS-1:0] partial;
   logic [WIDTH+RADIX_BITS:0]   sum;
   logic [2*WIDTH-1:0]        p_shift;

   // Magnitudes: -(most negative) wraps to 2^(W-1), which is exactly the
   // right unsigned magnitude, so no extra bit is needed.
   always_comb begin
      mag_a = (sign_mode && a[WIDTH-1]) ? -a : a;
      mag_b = (sign_mode && b[WIDTH-1]) ? -b : b;
   end

   // One radix step: add mcand * (low multiplier digit) into the upper half
   // and shift the whole accumulator right by one digit. The sum carries one
   // spare bit so no carry can be dropped before the shift.
   always_comb begin
      partial = {{RADIX_BITS{1'b0}}, mcand} * {{WIDTH{1'b0}}, p[RADIX_BITS-1:0]};
      sum     = {1'b0, partial} + {{(RADIX_BITS+1){1'b0}}, p[2*WIDTH-1:WIDTH]};
      p_shift = (2*WIDTH)'({sum, p[WIDTH-1:0]} >> RADIX_BITS);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == '0) begin
               state_next = FIX;
            end
         end
         FIX: begin
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand <= '0;
         p     <= '0;
         cnt   <= '0;
         neg   <= 1'b0;
         z     <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= mag_a;
                  p     <= {{WIDTH{1'b0}}, mag_b};
                  cnt   <= CNT_LOAD;
                  neg   <= sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               end
            end
            RUN: begin
               p <= p_shift;
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            FIX: begin
               z    <= neg ? -p : p;
               done <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - directed self-checking bench for mult_seq

module tb_mult_seq;

   logic        clk;
   logic        reset;

   // Default configuration: WIDTH=32, RADIX_BITS=2 (latency 17)
   logic        start, sign_mode, busy, done;
   logic [31:0] a, b;
   logic [63:0] z;

   // WIDTH=16, RADIX_BITS=4 (latency 5)
   logic        start16, sm16, busy16, done16;
   logic [15:0] a16, b16;
   logic [31:0] z16;

   // WIDTH=32, RADIX_BITS=1 (latency 33)
   logic        start1, sm1, busy1, done1;
   logic [31:0] a1, b1;
   logic [63:0] z1;

   int n_cmp = 0;
   int n_err = 0;
   logic busy_ok;

   mult_seq #(.WIDTH(32), .RADIX_BITS(2)) dut (
      .clk(clk), .reset(reset), .start(start), .sign_mode(sign_mode),
      .a(a), .b(b), .busy(busy), .done(done), .z(z)
   );

   mult_seq #(.WIDTH(16), .RADIX_BITS(4)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .sign_mode(sm16),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .z(z16)
   );

   mult_seq #(.WIDTH(32), .RADIX_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .sign_mode(sm1),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .z(z1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; returns just after the negedge following edge 0.
   task automatic launch(input logic sm, input logic [31:0] aa, input logic [31:0] bb);
      sign_mode = sm;
      a         = aa;
      b         = bb;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      a         = $urandom;
      b         = $urandom;
      sign_mode = $urandom_range(0, 1);
   endtask

   // Counts edges until done is seen; n is the edge index at which done appears.
   task automatic wait_done(output int n);
      n       = 0;
      busy_ok = 1'b1;
      while (!done && n < 100) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic mult_check(input string tag, input logic sm, input logic [31:0] aa,
                             input logic [31:0] bb, input logic [63:0] exp);
      int n;
      launch(sm, aa, bb);
      wait_done(n);
      check_eq({tag, "_lat"}, 64'(n), 64'd17);
      check_eq({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
      check_eq({tag, "_z"}, z, exp);
      check_eq({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
      @(negedge clk);
      check_eq({tag, "_done_fall"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int n;
      logic [63:0] first;
      longint r;

      reset = 1'b0;
      start = 1'b0; sign_mode = 1'b0; a = '0; b = '0;
      start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
      start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;

      repeat (3) @(negedge clk);
      check_eq("rst_z", z, 64'd0);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_done", {63'd0, done}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", {63'd0, busy}, 64'd0);

      mult_check("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      mult_check("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
      mult_check("s_minsq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      mult_check("s_m1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      mult_check("u_m1m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      mult_check("s_5xm3", 1'b1, 32'h0000_0005, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1);
      mult_check("zero", 1'b0, 32'h0000_0000, 32'h1234_5678, 64'd0);

      // Starts with new operands at edges 3 and 10 must be ignored.
      launch(1'b0, 32'h0000_1234, 32'h0000_0010);
      n = 0;
      while (!done && n < 100) begin
         start = (n == 2 || n == 9);
         a     = 32'd5;
         b     = 32'd5;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check_eq("ign_lat", 64'(n), 64'd17);
      check_eq("ign_z", z, 64'h0000_0000_0001_2340);
      @(negedge clk);
      check_eq("ign_idle", {63'd0, busy}, 64'd0);

      // Back-to-back: second start issued in the done cycle of the first.
      launch(1'b1, 32'hFFFF_FFFD, 32'h0000_0005);
      wait_done(n);
      check_eq("b2b_lat1", 64'(n), 64'd17);
      first = z;
      check_eq("b2b_z1", first, 64'hFFFF_FFFF_FFFF_FFF1);
      launch(1'b0, 32'd7, 32'd6);
      check_eq("b2b_done_fall", {63'd0, done}, 64'd0);
      check_eq("b2b_busy", {63'd0, busy}, 64'd1);
      check_eq("b2b_hold0", z, 64'hFFFF_FFFF_FFFF_FFF1);
      repeat (8) @(negedge clk);
      check_eq("b2b_hold8", z, 64'hFFFF_FFFF_FFFF_FFF1);
      wait_done(n);
      check_eq("b2b_lat2", 64'(n + 8), 64'd17);
      check_eq("b2b_z2", z, 64'h0000_0000_0000_002A);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      launch(1'b0, 32'd9, 32'd9);
      repeat (7) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_busy", {63'd0, busy}, 64'd0);
      check_eq("arst_done", {63'd0, done}, 64'd0);
      check_eq("arst_z", z, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      mult_check("post_rst", 1'b0, 32'd2, 32'd3, 64'd6);

      // WIDTH=16, RADIX_BITS=4 against a reference product.
      for (int i = 0; i < 8; i++) begin
         sm16    = i[0];
         a16     = (i == 0) ? 16'h8000 : 16'($urandom);
         b16     = (i == 0) ? 16'h8000 : 16'($urandom);
         r       = sm16 ? longint'($signed(a16)) * longint'($signed(b16))
                        : longint'(a16) * longint'(b16);
         start16 = 1'b1;
         @(negedge clk);
         start16 = 1'b0;
         n = 0;
         while (!done16 && n < 50) begin
            @(negedge clk);
            n++;
         end
         check_eq($sformatf("w16_lat%0d", i), 64'(n), 64'd5);
         check_eq($sformatf("w16_z%0d", i), {32'd0, z16}, {32'd0, r[31:0]});
         @(negedge clk);
      end

      // RADIX_BITS=1: latency 33.
      sm1 = 1'b0; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("r1_lat", 64'(n), 64'd33);
      check_eq("r1_z", z1, 64'hFFFF_FFFE_0000_0001);
      @(negedge clk);
      sm1 = 1'b1; a1 = 32'h8000_0000; b1 = 32'h0000_0003; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("r1_lat2", 64'(n), 64'd33);
      check_eq("r1_z2", z1, 64'hFFFF_FFFE_8000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
